// File: rtl/cavlc_cnt.sv
// cavlc_cnt: per-4x4-block CAVLC statistics gathered by a 16-cycle reverse zigzag scan
module cavlc_cnt (
   input  logic               clk,
   input  logic               rst,
   input  logic               h264_reset,
   input  logic               dctq_valid,
   input  logic [9:0]         topleft_x,
   input  logic [9:0]         topleft_y,
   input  logic signed [14:0] DCTQ_4x4 [0:3][0:3],
   output logic               cavlc_cnt_ready,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [4:0]         total_coeff,
   output logic [1:0]         trailing_ones,
   output logic [3:0]         total_zeros,
   output logic [2:0]         t1_signs,
   output logic signed [14:0] levels [0:15],
   output logic [3:0]         runs [0:15],
   output logic [9:0]         out_x,
   output logic [9:0]         out_y
);
   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
   localparam logic [3:0] ZZ [0:15] = '{4'd0, 4'd1, 4'd4, 4'd8, 4'd5, 4'd2, 4'd3, 4'd6,
                                        4'd9, 4'd12, 4'd13, 4'd10, 4'd7, 4'd11, 4'd14, 4'd15};
   state_t state, state_nxt;
   logic signed [14:0] blk [0:15];
   logic [3:0] idx;
   logic t1_stop, clr, cap, nz, one;
   logic signed [14:0] c;
   assign clr = rst | h264_reset;
   assign cavlc_cnt_ready = state == IDLE;
   assign out_valid = state == DONE;
   assign cap = dctq_valid & cavlc_cnt_ready;
   assign c = blk[idx];
   assign nz = c != '0;
   assign one = c == 15'sd1 || c == -15'sd1;
   // next state: capture starts the scan, index 0 ends it, handshake releases the result
   always_comb begin
      state_nxt = state == IDLE ? (dctq_valid ? SCAN : IDLE) :
                  state == SCAN ? (idx == '0 ? DONE : SCAN) :
                  (out_ready ? IDLE : DONE);
   end
   // state register
   always_ff @(posedge clk) state <= clr ? IDLE : state_nxt;
   // capture in zigzag order, then accumulate one coefficient per scan cycle from index 15 down
   always_ff @(posedge clk) begin
      if (clr || cap) begin
         total_coeff   <= '0;
         trailing_ones <= '0;
         total_zeros   <= '0;
         t1_signs      <= '0;
         t1_stop       <= 1'b0;
         idx           <= 4'd15;
         out_x         <= clr ? '0 : topleft_x;
         out_y         <= clr ? '0 : topleft_y;
         for (int i = 0; i < 16; i++) begin
            levels[i] <= '0;
            runs[i]   <= '0;
            blk[i]    <= clr ? '0 : DCTQ_4x4[ZZ[i][3:2]][ZZ[i][1:0]];
         end
      end else if (state == SCAN) begin
         idx <= idx - 4'd1;
         if (nz) begin
            levels[total_coeff[3:0]] <= c;
            total_coeff <= total_coeff + 5'd1;
            if (!t1_stop && one && trailing_ones != 2'd3) begin
               t1_signs[trailing_ones] <= c[14];
               trailing_ones <= trailing_ones + 2'd1;
            end else
               t1_stop <= 1'b1;
         end else if (total_coeff != '0) begin
            total_zeros <= total_zeros + 4'd1;
            runs[total_coeff[3:0] - 4'd1] <= runs[total_coeff[3:0] - 4'd1] + 4'd1;
         end
      end
   end
endmodule

// File: tb/tb_cavlc_cnt.sv
// tb_cavlc_cnt: random and directed blocks checked against a list-based CAVLC statistics model
module tb_cavlc_cnt;
   logic clk = 0, rst = 1, h264_reset = 0, dctq_valid = 0, out_ready = 0;
   logic [9:0] topleft_x = '0, topleft_y = '0;
   logic signed [14:0] dctq [0:3][0:3];
   logic cavlc_cnt_ready, out_valid;
   logic [4:0] total_coeff;
   logic [1:0] trailing_ones;
   logic [3:0] total_zeros;
   logic [2:0] t1_signs;
   logic signed [14:0] levels [0:15];
   logic [3:0] runs [0:15];
   logic [9:0] out_x, out_y;
   int checks = 0, errors = 0;
   int zr [16] = '{0, 0, 1, 2, 1, 0, 0, 1, 2, 3, 3, 2, 1, 2, 3, 3};
   int zc [16] = '{0, 1, 0, 0, 1, 2, 3, 2, 1, 0, 1, 2, 3, 3, 2, 3};
   int blkv [16];
   int e_tc, e_t1, e_tz, e_sg, e_x, e_y;
   int e_lv [16];
   int e_rn [16];

   // free-running clock
   always #5 clk = ~clk;

   cavlc_cnt dut (
      .clk(clk), .rst(rst), .h264_reset(h264_reset), .dctq_valid(dctq_valid),
      .topleft_x(topleft_x), .topleft_y(topleft_y), .DCTQ_4x4(dctq),
      .cavlc_cnt_ready(cavlc_cnt_ready), .out_valid(out_valid), .out_ready(out_ready),
      .total_coeff(total_coeff), .trailing_ones(trailing_ones), .total_zeros(total_zeros),
      .t1_signs(t1_signs), .levels(levels), .runs(runs), .out_x(out_x), .out_y(out_y)
   );

   task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // nonzero positions listed high to low; everything follows from that list
   task automatic model();
      int pos [$];
      for (int i = 15; i >= 0; i--) if (blkv[i] != 0) pos.push_back(i);
      e_tc = pos.size();
      for (int k = 0; k < 16; k++) begin
         e_lv[k] = 0;
         e_rn[k] = 0;
      end
      for (int k = 0; k < e_tc; k++) begin
         e_lv[k] = blkv[pos[k]];
         e_rn[k] = (k == e_tc - 1) ? pos[k] : pos[k] - pos[k + 1] - 1;
      end
      e_tz = e_tc > 0 ? pos[0] + 1 - e_tc : 0;
      e_t1 = 0;
      e_sg = 0;
      while (e_t1 < e_tc && e_t1 < 3 && (e_lv[e_t1] == 1 || e_lv[e_t1] == -1)) begin
         if (e_lv[e_t1] < 0) e_sg |= 1 << e_t1;
         e_t1++;
      end
   endtask

   task automatic check_out(input string p);
      check({p, "_total_coeff"}, total_coeff, e_tc);
      check({p, "_trailing_ones"}, trailing_ones, e_t1);
      check({p, "_total_zeros"}, total_zeros, e_tz);
      check({p, "_t1_signs"}, t1_signs, e_sg);
      check({p, "_out_x"}, out_x, e_x);
      check({p, "_out_y"}, out_y, e_y);
      for (int k = 0; k < 16; k++) begin
         check($sformatf("%s_levels%0d", p, k), levels[k], e_lv[k]);
         check($sformatf("%s_runs%0d", p, k), runs[k], e_rn[k]);
      end
   endtask

   task automatic capture();
      int n = 0;
      @(negedge clk);
      while (!cavlc_cnt_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("ready_wait", cavlc_cnt_ready, 1);
      for (int i = 0; i < 16; i++) dctq[zr[i]][zc[i]] = 15'(blkv[i]);
      topleft_x = 10'($urandom);
      topleft_y = 10'($urandom);
      e_x = topleft_x;
      e_y = topleft_y;
      dctq_valid = 1;
      @(posedge clk);
   endtask

   task automatic run_block(input string p, input int hold, input int delay);
      model();
      capture();
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         if (k == 1) begin
            check({p, "_ready_low"}, cavlc_cnt_ready, 0);
            dctq_valid = hold[0];
         end
         if (hold != 0) begin
            for (int i = 0; i < 16; i++) dctq[zr[i]][zc[i]] = 15'($urandom);
            topleft_x = 10'($urandom);
         end
         check($sformatf("%s_valid_early%0d", p, k), out_valid, 0);
         @(posedge clk);
      end
      @(negedge clk);
      check({p, "_valid_t17"}, out_valid, 1);
      check_out(p);
      for (int d = 0; d < delay; d++) begin
         @(posedge clk);
         @(negedge clk);
         check({p, "_valid_hold"}, out_valid, 1);
         check({p, "_ready_hold"}, cavlc_cnt_ready, 0);
         check_out({p, "_hold"});
      end
      out_ready = 1;
      dctq_valid = 0;
      @(posedge clk);
      @(negedge clk);
      check({p, "_valid_drop"}, out_valid, 0);
      check({p, "_ready_t18"}, cavlc_cnt_ready, 1);
      out_ready = 0;
   endtask

   task automatic rnd_block(input int dense);
      for (int i = 0; i < 16; i++) begin
         int r = int'($urandom_range(0, 9));
         if (r < 5 && dense == 0) blkv[i] = 0;
         else if (r < 7) blkv[i] = $urandom_range(0, 1) ? 1 : -1;
         else if (r < 9) blkv[i] = int'($urandom_range(0, 16)) - 8;
         else blkv[i] = int'($urandom_range(0, 32767)) - 16384;
      end
   endtask

   initial begin
      int seen;
      for (int i = 0; i < 16; i++) dctq[zr[i]][zc[i]] = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_ready", cavlc_cnt_ready, 1);
      check("rst_valid", out_valid, 0);
      check("rst_total_coeff", total_coeff, 0);
      check("rst_out_x", out_x, 0);
      check("rst_levels0", levels[0], 0);
      check("rst_runs0", runs[0], 0);
      rst = 0;
      blkv = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      run_block("zero", 0, 0);
      blkv = '{0, 3, 0, 1, -1, -1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
      run_block("mixed", 0, 0);
      blkv = '{1, -1, 1, -1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      run_block("ones", 0, 0);
      for (int i = 0; i < 16; i++) blkv[i] = -16384;
      run_block("full", 0, 0);
      rnd_block(0);
      run_block("stall", 1, 5);
      rnd_block(0);
      capture();
      dctq_valid = 0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (k == 8) h264_reset = 1;
         @(posedge clk);
      end
      @(negedge clk);
      h264_reset = 0;
      check("abort_ready", cavlc_cnt_ready, 1);
      check("abort_valid", out_valid, 0);
      check("abort_total_coeff", total_coeff, 0);
      check("abort_out_x", out_x, 0);
      seen = 0;
      repeat (20) begin
         @(negedge clk);
         seen |= int'(out_valid);
      end
      check("abort_no_valid", seen, 0);
      rnd_block(0);
      run_block("after_abort", 0, 0);
      for (int n = 0; n < 40; n++) begin
         rnd_block(n % 5 == 0);
         run_block($sformatf("rnd%0d", n), int'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
